// File: rtl/noc_pkg.sv
// Shared NoC constants for the neuron-to-router injection path.
// Packet geometry, injector FSM encoding and AER field offsets.
package noc_pkg;

  localparam int PACKET_SIZE      = 32;
  localparam int FLIT_SIZE        = 4;
  localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam int X_DEST_LSB = 24;
  localparam int Y_DEST_LSB = 16;
  localparam int DEST_W     = 8;

endpackage

// File: rtl/packet_fifo.sv
// Small synchronous packet FIFO with registered full/empty.
// Also exposes the post-edge fill level for registered status outputs.
module packet_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level_nxt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic             do_push;
  logic             do_pop;

  // A full FIFO rejects writes even if a pop happens this cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    unique case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (PTR_W+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/neuron_packet_injector.sv
// Buffers neuron spike packets and serializes them MSB-nibble-first
// into a router input port under full back-pressure.
module neuron_packet_injector #(
  parameter int PACKET_SIZE    = noc_pkg::PACKET_SIZE,
  parameter int FLIT_SIZE      = noc_pkg::FLIT_SIZE,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_PTR_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PACKET_SIZE-1:0] packet_in,
  input  logic                   packet_write_req,
  output logic                   packet_full,
  output logic [FLIT_SIZE-1:0]   flit_out,
  output logic                   wr_req_out,
  input  logic                   full_in,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  import noc_pkg::*;

  localparam int FLITS = PACKET_SIZE / FLIT_SIZE;
  localparam int CNT_W = $clog2(FLITS);

  logic [0:0]             state_q;
  logic [0:0]             state_d;
  logic [PACKET_SIZE-1:0] shreg_q;
  logic [PACKET_SIZE-1:0] head;
  logic [CNT_W-1:0]       cnt_q;
  logic [FIFO_PTR_WIDTH:0] level_nxt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   xfer;
  logic                   last;
  logic                   pop;
  logic                   busy_q;
  logic [7:0]             drop_q;

  packet_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (packet_write_req),
    .push_data (packet_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level_nxt (level_nxt)
  );

  assign xfer = (state_q == SEND) && !full_in;
  assign last = xfer && (cnt_q == CNT_W'(FLITS - 1));
  // Reloading on the final flit keeps back-to-back packets bubble-free.
  assign pop  = !fifo_empty && ((state_q == IDLE) || last);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (!fifo_empty) state_d = SEND;
      last:              if (fifo_empty) state_d = IDLE;
      default:           state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SEND) || (level_nxt != '0);
      if (pop) begin
        shreg_q <= head;
        cnt_q   <= '0;
      end else if (xfer) begin
        shreg_q <= shreg_q << FLIT_SIZE;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (packet_write_req && fifo_full && (drop_q != 8'hff))
        drop_q <= drop_q + 8'd1;
    end
  end

  assign flit_out    = shreg_q[PACKET_SIZE-1 -: FLIT_SIZE];
  assign wr_req_out  = xfer;
  assign packet_full = fifo_full;
  assign busy        = busy_q;
  assign drop_cnt    = drop_q;

endmodule

// File: doc/neuron_packet_injector.md
# neuron_packet_injector

Injection stage between a neuron core's spike-packet output and a 4-bit router input port. Accepts 32-bit AER spike packets from the neuron on a one-cycle write strobe and buffers them in a small packet FIFO. Serializes each packet into eight 4-bit flits, most-significant nibble first, and drives them into the router under the router's `full` back-pressure. Decouples neuron firing bursts from router congestion and counts packets dropped on overflow.

## Interface
- `PACKET_SIZE`, 32, packet width in bits
- `FLIT_SIZE`, 4, flit width in bits; `PACKET_SIZE` must be a multiple of it
- `FIFO_DEPTH`, 4, packet FIFO entries; power of two, ≥2
- `FIFO_PTR_WIDTH`, 2, log2(`FIFO_DEPTH`)
- `clk`  in  1  single clock for the whole block
- `rst_n`  in  1  reset, asynchronous, active-low
- `packet_in`  in  `PACKET_SIZE`  spike packet from neuron; bits [31:24] X dest, [23:16] Y dest, [15:0] payload
- `packet_write_req`  in  1  one-cycle strobe; `packet_in` valid this cycle
- `packet_full`  out  1  registered; high when FIFO holds `FIFO_DEPTH` packets
- `flit_out`  out  `FLIT_SIZE`  flit to router input port, registered
- `wr_req_out`  out  1  flit transfer this cycle
- `full_in`  in  1  router input buffer full; no transfer while high
- `busy`  out  1  high when FIFO non-empty or a packet is mid-serialization
- `drop_cnt`  out  8  saturating count of packets dropped on overflow

## Operation
- Reset values: `packet_full`=0, `flit_out`=0, `wr_req_out`=0, `busy`=0, `drop_cnt`=0. FIFO is empty and the FSM is in IDLE.
- FIFO write: `packet_write_req` high with count < `FIFO_DEPTH` pushes `packet_in`.
  - With count == `FIFO_DEPTH`, the packet is dropped and `drop_cnt` increments.
  - `drop_cnt` saturates at 255.
  - A pop in the same cycle does not rescue a write to a full FIFO; it is still dropped.
- Simultaneous push and pop with 0 < count < `FIFO_DEPTH` leaves count unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into the shift register, clear the flit counter, go to SEND.
  - SEND: `flit_out` = shift register [MSB nibble]; `wr_req_out` = ~`full_in` (combinational).
    - On transfer: shift left by `FLIT_SIZE`, increment the 3-bit flit counter.
    - On the transfer of flit 7, if the FIFO is non-empty, pop and load the next packet with no bubble; otherwise go to IDLE.
- `full_in` high in SEND holds `flit_out` stable and keeps `wr_req_out` low. There is no timeout.
- A packet is never split or reordered. Flits of one packet are contiguous apart from `full_in` stalls.
- Reset asserted mid-packet abandons the partial packet and flushes the FIFO. `wr_req_out` falls asynchronously.

## Timing
- Latency: strobe in cycle 0 with the block idle and `full_in` low gives the first flit with `wr_req_out` high in cycle 2, and the last flit in cycle 9.
- Throughput: one flit per cycle. A back-to-back packet's flit 0 follows the previous packet's flit 7 in the next cycle.
- `packet_full` reflects count after the current edge. The neuron sees it one cycle after the write that filled the FIFO.
- `busy` is registered. It falls the cycle after the final flit transfer when the FIFO is empty.

## Structure
- Shared package `noc_pkg`:
  - constants `PACKET_SIZE`, `FLIT_SIZE`, `FLITS_PER_PACKET`=8
  - FSM state encoding (IDLE=0, SEND=1)
  - packet field offsets for X/Y destination
- Sub-module `packet_fifo`: synchronous FIFO, registered count/full/empty, async active-low reset, push/pop ports.
- The top level holds the FSM, shift register, flit counter and drop counter.

## Test plan
- Single packet 0xA1B2C3D4, `full_in`=0 -> flits A,1,B,2,C,3,D,4 in cycles 2–9, each with `wr_req_out`=1. `busy` falls at cycle 10.
- Two strobes on consecutive cycles (0x11111111, 0x22222222) -> 16 consecutive transfers, no bubble between flit 7 and the next flit 0.
- `full_in` held high for cycles 4–6 during a packet -> `wr_req_out`=0 and `flit_out` frozen on flit 2 for three cycles, then resume. Total 8 transfers.
- `full_in` held high, 6 strobes -> 4 stored, `packet_full`=1, `drop_cnt`=1 (the first packet is in the shift register). After releasing `full_in`, 5 packets emerge in order.
- 300 strobes into a full FIFO -> `drop_cnt` saturates at 255.
- `rst_n` pulsed low at flit 3 with 2 packets queued -> all outputs 0 immediately, `busy`=0, no further flits after release.
